// File: rtl/spi_master.sv
// spi_master: parametrised SPI master with a programmable SCLK divider,
// per-transfer CPOL/CPHA, one-hot active-low slave selects and an rx_valid pulse.
// Transfers are full-duplex, MSB-first and W_Data bits long.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   tx_data/tx_valid  word to send and its request (valid/ready handshake)
//   tx_ready          high in IDLE; acceptance on tx_valid & tx_ready
//   cs_sel, cpol,     slave index and SPI mode, sampled at acceptance
//   cpha
//   loopback          (SPI_MASTER_LOOPBACK_EN only) RX from internal mosi, ss_n held high
//   rx_data/rx_valid  last received word and its one-cycle completion pulse
//   busy              high from acceptance until completion
//   sclk, mosi, miso  SPI serial pins
//   ss_n              active-low slave selects (2**W_Sel lines)
//
// Optional feature macro: SPI_MASTER_LOOPBACK_EN.

`ifndef W_CPU
`define W_CPU 8
`endif

module spi_master #(
    parameter int unsigned W_Data  = `W_CPU,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned W_Sel   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_Data-1:0]    tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [W_Sel-1:0]     cs_sel,
    input  logic                 cpol,
    input  logic                 cpha,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [W_Data-1:0]    rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic [(2**W_Sel)-1:0] ss_n
);

    localparam int unsigned N_SS   = 2 ** W_Sel;
    localparam int unsigned N_EDGE = 2 * W_Data;
    localparam int unsigned W_EC   = ($clog2(N_EDGE + 1) > 6) ? $clog2(N_EDGE + 1) : 6;
    localparam int unsigned W_DIV  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [W_DIV-1:0]    div_q, div_d;
    logic [W_EC-1:0]     edge_q, edge_d;
    logic [W_Data-1:0]   tx_sr_q, tx_sr_d;
    logic [W_Data-1:0]   rx_sr_q, rx_sr_d;
    logic [W_Data-1:0]   rx_data_q, rx_data_d;
    logic                cpha_q, cpha_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_ready_q, tx_ready_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [N_SS-1:0]     ss_n_q, ss_n_d;

    logic                tick;
    logic                accept;
    logic                lead_edge;
    logic                last_edge;
    logic                rx_bit;
    logic                lb_in;

    // One divider period has elapsed; an SCLK edge (or phase end) happens now.
    assign tick      = (div_q == W_DIV'(CLK_DIV - 1));
    assign accept    = (state_q == IDLE) && tx_valid && tx_ready_q;
    // edge_q counts edges already produced, so the upcoming edge is edge_q+1.
    assign lead_edge = ~edge_q[0];
    assign last_edge = (edge_q == W_EC'(N_EDGE - 1));

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;
    assign lb_in  = loopback;
    assign rx_bit = lb_q ? mosi_q : miso;
`else
    assign lb_in  = 1'b0;
    assign rx_bit = miso;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)             state_d = LEAD;
            LEAD:    if (tick)               state_d = SHIFT;
            SHIFT:   if (tick && last_edge)  state_d = TRAIL;
            TRAIL:   if (tick)               state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Next values for the datapath and registered outputs.
    always_comb begin
        div_d      = div_q;
        edge_d     = edge_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        cpha_d     = cpha_q;
        rx_valid_d = 1'b0;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d       = lb_q;
`endif

        case (state_q)
            IDLE: begin
                div_d  = '0;
                edge_d = '0;
                sclk_d = cpol;
                ss_n_d = '1;
                if (accept) begin
                    cpha_d     = cpha;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    rx_sr_d    = '0;
                    ss_n_d     = lb_in ? {N_SS{1'b1}} : ~(N_SS'(1) << cs_sel);
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d       = loopback;
`endif
                    // CPHA=0 presents the MSB before the first edge.
                    if (!cpha) begin
                        mosi_d  = tx_data[W_Data-1];
                        tx_sr_d = {tx_data[W_Data-2:0], 1'b0};
                    end else begin
                        tx_sr_d = tx_data;
                    end
                end
            end

            LEAD, SHIFT: begin
                div_d = tick ? '0 : div_q + W_DIV'(1);
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + W_EC'(1);
                    // Sample on leading edges for CPHA=0, trailing for CPHA=1.
                    if (cpha_q ^ lead_edge) begin
                        rx_sr_d = {rx_sr_q[W_Data-2:0], rx_bit};
                    end
                    // Shift on leading edges for CPHA=1; on non-final trailing edges for CPHA=0.
                    if (cpha_q ? lead_edge : (!lead_edge && !last_edge)) begin
                        mosi_d  = tx_sr_q[W_Data-1];
                        tx_sr_d = {tx_sr_q[W_Data-2:0], 1'b0};
                    end
                end
            end

            TRAIL: begin
                div_d = tick ? '0 : div_q + W_DIV'(1);
                if (tick) begin
                    ss_n_d     = '1;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end

            default: begin
                ss_n_d = '1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= '0;
            edge_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cpha_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q       <= 1'b0;
`endif
        end else begin
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            cpha_q     <= cpha_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q       <= lb_d;
`endif
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule
